sort_readout: RTL

Drains the insertion-sort cell array once per frame. It sits directly downstream of the sorter: it watches the sorter's `dav_i` and `updating` outputs, snapshots the sorted data/metadata array once the chain is quiet, and streams the occupied entries best-first over a valid/ready interface. It then pulses `flush_o`, which clears the sorter for the next frame.

---
 rtl/sort_pkg.sv | 22 ++
 rtl/quiet_detect.sv | 34 +++
 rtl/sort_readout.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// sort_pkg: shared definitions for the insertion sorter and its readout.
//   - default key/metadata widths and cell count used by both blocks
//   - readout FSM state type
//   - occ_w(): width of an occupancy counter that must hold 0..depth
package sort_pkg;

  localparam int unsigned SORTB_DEFAULT = 8;
  localparam int unsigned METAB_DEFAULT = 32;
  localparam int unsigned DEPTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_QUIET,
    STREAM,
    FLUSH
  } readout_state_t;

  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/quiet_detect.sv
// quiet_detect: counts consecutive quiet cycles while enabled.
//   clk, rst   clock, asynchronous active-high reset
//   en         counting window (readout is waiting for the sorter to settle)
//   quiet      current cycle is quiet (no dav, no cell updating)
//   quiet_hit  one-cycle strobe: this cycle completes QUIET quiet cycles
module quiet_detect #(
  parameter int unsigned QUIET = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic quiet,
  output logic quiet_hit
);

  localparam int unsigned CW = $clog2(QUIET + 1);

  logic [CW-1:0] cnt;

  // Hit is flagged on the cycle whose edge would bring the count to QUIET,
  // so the capture happens on that same edge.
  assign quiet_hit = en && quiet && (cnt == CW'(QUIET - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || !quiet || quiet_hit) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sort_readout.sv
// sort_readout: drains the insertion-sort cell array once per frame.
//   clk, rst       clock, asynchronous active-high reset
//   dav_i          sorter input strobe, counted as occupancy
//   frame_i        end-of-frame pulse, starts a readout
//   sort_data_i    sorter keys, cell i at [i*SORTB +: SORTB]
//   sort_meta_i    sorter metadata, cell i at [i*METAB +: METAB]
//   sort_upd_i     per-cell updating flags from the sorter
//   valid_o/ready_i  output handshake
//   data_o, meta_o   entry key / metadata, best first
//   rank_o         0 for the best entry
//   last_o         final entry of the frame
//   flush_o        one-cycle pulse clearing the sorter
//   busy_o         readout in progress
//   err_o          sticky protocol error
module sort_readout
  import sort_pkg::*;
#(
  parameter int unsigned SORTB = SORTB_DEFAULT,
  parameter int unsigned METAB = METAB_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned QUIET = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dav_i,
  input  logic                       frame_i,
  input  logic [SORTB*DEPTH-1:0]     sort_data_i,
  input  logic [METAB*DEPTH-1:0]     sort_meta_i,
  input  logic [DEPTH-1:0]           sort_upd_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [SORTB-1:0]           data_o,
  output logic [METAB-1:0]           meta_o,
  output logic [$clog2(DEPTH)-1:0]   rank_o,
  output logic                       last_o,
  output logic                       flush_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int unsigned OW = occ_w(DEPTH);
  localparam int unsigned RW = $clog2(DEPTH);

  readout_state_t state, state_nx;

  logic [OW-1:0]    occ;
  logic [OW-1:0]    n;
  logic [RW-1:0]    rank;
  logic [RW-1:0]    sel;
  logic [SORTB-1:0] snap_data [DEPTH];
  logic [METAB-1:0] snap_meta [DEPTH];
  logic             err;
  logic             quiet_hit;
  logic             counting;

  quiet_detect #(
    .QUIET(QUIET)
  ) u_quiet (
    .clk      (clk),
    .rst      (rst),
    .en       (state == WAIT_QUIET),
    .quiet    ((sort_upd_i == '0) && !dav_i),
    .quiet_hit(quiet_hit)
  );

  // Occupancy only tracks strobes that reach the sorter before capture.
  assign counting = (state == IDLE) || (state == WAIT_QUIET);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    valid_o  = 1'b0;
    flush_o  = 1'b0;
    busy_o   = (state != IDLE);
    case (state)
      IDLE: begin
        if (frame_i) state_nx = WAIT_QUIET;
      end
      WAIT_QUIET: begin
        if (quiet_hit) state_nx = (occ == '0) ? FLUSH : STREAM;
      end
      STREAM: begin
        valid_o = 1'b1;
        if (ready_i && last_o) state_nx = FLUSH;
      end
      FLUSH: begin
        flush_o  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ  <= '0;
      n    <= '0;
      rank <= '0;
      err  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        snap_data[i] <= '0;
        snap_meta[i] <= '0;
      end
    end else begin
      // A capture cycle is quiet, so it never coincides with a counted dav.
      if (quiet_hit) begin
        occ <= '0;
      end else if (dav_i && counting && (occ != OW'(DEPTH))) begin
        occ <= occ + OW'(1);
      end

      if (quiet_hit) begin
        n    <= occ;
        rank <= '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
          snap_data[i] <= sort_data_i[i*SORTB +: SORTB];
          snap_meta[i] <= sort_meta_i[i*METAB +: METAB];
        end
      end else if ((state == STREAM) && ready_i && !last_o) begin
        rank <= rank + RW'(1);
      end

      if ((dav_i && !counting) || (frame_i && (state != IDLE))) begin
        err <= 1'b1;
      end
    end
  end

  // Best entry lives in the highest cell.
  assign sel    = RW'(DEPTH - 1) - rank;
  assign data_o = snap_data[sel];
  assign meta_o = snap_meta[sel];
  assign rank_o = rank;
  assign last_o = (state == STREAM) && (OW'(rank) == (n - OW'(1)));
  assign err_o  = err;

endmodule
